// File: rtl/mem_line_resp_pkg.sv
// Shared definitions for the line-granular memory responder.
// Holds the FSM state encoding, the line and address widths, the latency
// counter width and the default values of the block parameters.
package mem_line_resp_pkg;

  localparam int LINE_W          = 128;
  localparam int ADDR_W          = 28;
  localparam int LATENCY_DEF     = 4;
  localparam int DEPTH_LINES_DEF = 64;
  // Wide enough for the largest legal LATENCY-1 (14).
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_line_array.sv
// Line storage for mem_line_resp.
// One synchronous write port and one combinational read port. Asynchronous
// active-low reset clears every line to zero.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_we     write enable
//   i_waddr  write line index
//   i_wdata  write line data
//   i_raddr  read line index
//   o_rdata  read line data (combinational)
module mem_line_array
  import mem_line_resp_pkg::*;
#(
  parameter int DEPTH = DEPTH_LINES_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_lines [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_lines[i] <= '0;
      end
    end else if (i_we) begin
      r_lines[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_lines[i_raddr];

endmodule

// File: rtl/mem_line_resp.sv
// Line-granular memory responder for a cache refill/writeback interface.
// A level-held read or write request is accepted in IDLE, completes with a
// one-cycle mem_ready pulse LATENCY cycles after acceptance, then spends one
// DONE cycle before accepting again. Protocol violations (read and write
// together, or a request dropped before completion) set a sticky proto_err.
// Ports:
//   clk           clock
//   proc_reset_n  asynchronous active-low reset
//   mem_read      read request (level)
//   mem_write     write request (level)
//   mem_addr      line address; only the low log2(DEPTH_LINES) bits index
//   mem_wdata     write line data
//   mem_rdata     read line data, valid only during the mem_ready cycle
//   mem_ready     one-cycle completion pulse
//   proto_err     sticky protocol-error flag
module mem_line_resp
  import mem_line_resp_pkg::*;
#(
  parameter int LATENCY     = LATENCY_DEF,
  parameter int DEPTH_LINES = DEPTH_LINES_DEF
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [LINE_W-1:0]  r_wdata;
  logic               r_op_wr;
  logic [LINE_W-1:0]  r_rdata;
  logic               r_ready;
  logic               r_err;

  state_t             w_state_nxt;
  logic               w_req;
  logic               w_accept;
  logic               w_abort;
  logic               w_complete;
  logic               w_we;
  logic [LINE_W-1:0]  w_rd_line;
  // Address bits above the index alias onto the same line.
  logic               w_unused_addr_hi;

  assign w_unused_addr_hi = ^mem_addr[ADDR_W-1:IDX_W];
  assign w_req            = mem_read | mem_write;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A dropped request wins over completion, even on the final count.
        if (!w_req) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The write commits on the same edge that raises mem_ready.
  assign w_we = w_complete & r_op_wr;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_op_wr <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_complete;
      r_rdata <= (w_complete && !r_op_wr) ? w_rd_line : '0;
      if (w_accept) begin
        r_idx   <= mem_addr[IDX_W-1:0];
        r_wdata <= mem_wdata;
        r_op_wr <= mem_write;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if ((w_accept && mem_read && mem_write) || w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  mem_line_array #(
    .DEPTH (DEPTH_LINES),
    .IDX_W (IDX_W)
  ) u_lines (
    .i_clk   (clk),
    .i_rst_n (proc_reset_n),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_rd_line)
  );

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign proto_err = r_err;

endmodule

// File: tb/tb_mem_line_resp.sv
// Scoreboard bench for mem_line_resp: the driver computes each expected
// response from a plain line-array model and queues it; a negedge monitor
// pops and compares whenever mem_ready is seen.
module tb_mem_line_resp;
  import mem_line_resp_pkg::*;

  localparam int L = 4;
  localparam int D = 64;

  logic              clk = 1'b0;
  logic              proc_reset_n;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              proto_err;

  mem_line_resp #(.LATENCY(L), .DEPTH_LINES(D)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LINE_W-1:0] rdata;
    logic              err;
    int                cyc;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [LINE_W-1:0] model [D];
  logic              model_err;
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;
  int                last_rdy_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (proc_reset_n) begin
      if (mem_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 128'(1), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("rdata", mem_rdata, mon_e.rdata);
          chk("proto_err_at_ready", 128'(proto_err), 128'(mon_e.err));
          chk("ready_cycle", 128'(cyc), 128'(mon_e.cyc));
        end
      end else begin
        chk("rdata_zero_outside_ready", mem_rdata, '0);
      end
    end
  end

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Random address hitting indices 0..7 with random aliasing upper bits.
  function automatic logic [ADDR_W-1:0] rnd_addr();
    return ADDR_W'($urandom) & ~ADDR_W'(28'h38);
  endfunction

  task automatic do_req(input logic rd, input logic wr,
                        input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] data);
    exp_t e;
    exp_t dummy;
    int   idx;
    bit   got;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = data;
    @(posedge clk);
    #1;
    idx = int'(addr) % D;
    if (wr) begin
      model[idx] = data;
      e.rdata    = '0;
    end else begin
      e.rdata = model[idx];
    end
    if (rd && wr) model_err = 1'b1;
    e.err = model_err;
    e.cyc = cyc + L;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < L + 4 && !got; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        got          = 1'b1;
        last_rdy_cyc = cyc;
      end else begin
        // Address/data changes after acceptance must be ignored.
        mem_addr  = rnd_addr();
        mem_wdata = rnd_line();
      end
    end
    chk("ready_seen", 128'(got), 128'(1));
    if (!got && sb.size() > 0) dummy = sb.pop_back();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Accept a write, then drop it so it is sampled low k edges later.
  task automatic do_abort(input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] data, input int k);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    @(posedge clk);
    #1;
    repeat (k - 1) @(posedge clk);
    #1;
    mem_write = 1'b0;
    model_err = 1'b1;
    repeat (L + 2) @(negedge clk);
    chk("abort_proto_err", 128'(proto_err), 128'(1));
  endtask

  initial begin
    int r1;
    logic [LINE_W-1:0] d;
    proc_reset_n = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    model_err    = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    #12;
    chk("reset_ready", 128'(mem_ready), 128'(0));
    chk("reset_rdata", mem_rdata, '0);
    chk("reset_proto_err", 128'(proto_err), 128'(0));
    @(negedge clk);
    proc_reset_n = 1'b1;

    // Basic read after reset, then write and aliased read back.
    do_req(1'b1, 1'b0, 28'h0000005, '0);
    do_req(1'b0, 1'b1, 28'h0000003, 128'hDEADBEEF_0123_4567_89AB_CDEF_F0F0_0F0F);
    do_req(1'b1, 1'b0, 28'h0000043, '0);

    // Back-to-back completions are LATENCY+2 cycles apart.
    do_req(1'b1, 1'b0, 28'h0000003, '0);
    r1 = last_rdy_cyc;
    do_req(1'b1, 1'b0, 28'h0000005, '0);
    chk("b2b_gap", 128'(last_rdy_cyc - r1), 128'(L + 2));

    // Random clean traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) do_req(1'b0, 1'b1, rnd_addr(), rnd_line());
      else                           do_req(1'b1, 1'b0, rnd_addr(), '0);
    end

    // Write dropped two cycles after acceptance: no commit, sticky error.
    d = rnd_line();
    do_abort(28'h0000007, d, 2);
    do_req(1'b1, 1'b0, 28'h0000007, '0);

    // Read and write together: treated as a write.
    do_req(1'b1, 1'b1, 28'h0000010, 128'h1);
    do_req(1'b1, 1'b0, 28'h0000010, '0);

    // Random traffic including conflicts and aborts at every drop point.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       do_req(1'b0, 1'b1, rnd_addr(), rnd_line());
        1:       do_req(1'b1, 1'b1, rnd_addr(), rnd_line());
        2:       do_abort(rnd_addr(), rnd_line(), int'($urandom_range(1, L)));
        default: do_req(1'b1, 1'b0, rnd_addr(), '0);
      endcase
    end

    // Reset in the middle of a write: outputs clear at once, line stays 0.
    do_req(1'b0, 1'b1, 28'h0000015, rnd_line());
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 28'h0000015;
    mem_wdata = rnd_line();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    proc_reset_n = 1'b0;
    #1;
    chk("async_reset_ready", 128'(mem_ready), 128'(0));
    chk("async_reset_rdata", mem_rdata, '0);
    chk("async_reset_proto_err", 128'(proto_err), 128'(0));
    mem_write = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    model_err = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    do_req(1'b1, 1'b0, 28'h0000015, '0);
    do_req(1'b1, 1'b0, 28'h0000043, '0);

    repeat (L + 4) @(negedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
